alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//  Sequential execution wrapper around the 20-bit ALU component set. Accepts one operation per
//  request (valid/ready), computes it, and returns the result plus zero/sign/carry flags over a
//  response channel (valid/ready). Keeps a persistent carry flag that ADDC consumes.
//  Multi-bit shifts run serially, one position per cycle. Sits between the instruction
//  decode/issue stage and the register-file writeback.
// PARAMETERS
//  W        20   datapath width (a, b, result)
//  OPW      4    opcode width; 16 opcodes, one per demux lane
//  SHW      4    shift-count width; counts 0..15
// PORTS
//  clk          in   1    clock, rising edge
//  rst_n        in   1    asynchronous active-low reset
//  req_valid    in   1    request present
//  req_ready    out  1    unit can accept a request
//  req_op       in   OPW  opcode (see BEHAVIOUR)
//  req_a        in   W    operand A
//  req_b        in   W    operand B
//  req_shamt    in   SHW  shift count; used by SHFTL/SHFTR only
//  rsp_valid    out  1    response present
//  rsp_ready    in   1    consumer accepts response
//  rsp_result   out  W    primary result
//  rsp_result_b out  W    secondary result; SWAP only, otherwise 0
//  rsp_zero     out  1    result==0 (CMP: a==b)
//  rsp_sign     out  1    result[W-1] (CMP: a<b unsigned)
//  rsp_carry    out  1    current carry-flag register value
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; req_ready=0 while in reset; rsp_valid=0; rsp_result=0,
//   rsp_result_b=0; zero=0, sign=0, carry=0. An in-flight operation is discarded; nothing replays.
//  Opcodes: 0 ADD, 1 ADDC (a+b+carry), 2 SUB (a-b), 3 INC, 4 DEC, 5 AND, 6 OR, 7 XOR,
//   8 NOT a, 9 SHFTL by shamt, 10 SHFTR (logical) by shamt, 11 ROTL by 1, 12 ROTR by 1,
//   13 SWAP (result=b, result_b=a), 14 CMP (result=a), 15 PASS (result=a).
//  FSM: IDLE -> EXEC -> RESP -> IDLE; IDLE -> SHIFT -> RESP for op 9/10 with shamt!=0.
//   IDLE: req_ready=1; handshake fires when req_valid&&req_ready; operands and op are latched.
//   EXEC: one cycle; result and flags are registered.
//   SHIFT: a shift-by-1 is applied each cycle and a down-counter is decremented; leaves after
//    shamt cycles. shamt=0 takes the EXEC path and gives result=a.
//   RESP: rsp_valid=1; all rsp_* stay stable until rsp_ready; on rsp_ready -> IDLE.
//  Latency from accept edge to rsp_valid: 2 cycles (non-shift); 1+shamt cycles (shift, shamt>0).
//  No new request is accepted until the response is consumed. req_ready=0 in EXEC/SHIFT/RESP.
//   Throughput is 1 op / 3 cycles at best.
//  Arithmetic: all results are mod 2^W. Carry register is written only by ADD/ADDC/INC
//   (carry-out) and by SUB/DEC (borrow=1 when a<b, or when a==0 for DEC). All other ops leave it.
//  Zero and sign are recomputed for every op. Sign = result[W-1], except CMP.
//  Wrap: INC of 0xFFFFF -> 0, carry=1. DEC of 0 -> 0xFFFFF, carry=1 (borrow).
//  Shift-out bits are discarded; SHFTL 0x80001 by 1 -> 0x00002.
//  An unknown opcode cannot occur: the 4-bit op space is fully decoded.
// STRUCTURE
//  Shared package alu_pkg: W, OPW, SHW localparams; opcode enum alu_op_e; state enum exec_state_e.
//  One sub-module: alu_core (combinational op decode + compute: result, result_b, carry_out,
//   carry_we). The FSM, operand/shift registers and flag registers live in alu_exec_unit.
// TESTING
//  1 ADD a=0xFFFFF b=0x00001 -> result 0x00000, zero=1, carry=1; rsp_valid 2 cycles after accept.
//  2 After test 1, ADDC a=0x00010 b=0x00020 -> result 0x00031, carry=0 (carry-in consumed).
//  3 SHFTL a=0x00001 shamt=5 -> rsp_valid exactly 6 cycles after accept, result 0x00020;
//    shamt=0 -> result 0x00001, latency 2.
//  4 CMP a=0x00005 b=0x00009 -> zero=0, sign=1, carry unchanged; CMP a=b=0x12345 -> zero=1, sign=0.
//  5 Backpressure: hold rsp_ready=0 for 4 cycles with req_valid=1 -> rsp_* stable and req_ready=0
//    throughout; the second request is accepted only in the cycle after rsp_ready.
//  6 Reset mid-SHIFT (shamt=12, assert rst_n=0 at cycle 4) -> rsp_valid=0 and all outputs 0
//    immediately; after release, a SWAP a=0x0000A b=0x0000B returns 0x0000B / 0x0000A.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths, opcode encoding and FSM state encoding for the ALU execution unit.
package alu_pkg;

  localparam int unsigned W   = 20;
  localparam int unsigned OPW = 4;
  localparam int unsigned SHW = 4;

  typedef enum logic [OPW-1:0] {
    OpAdd   = 4'd0,
    OpAddc  = 4'd1,
    OpSub   = 4'd2,
    OpInc   = 4'd3,
    OpDec   = 4'd4,
    OpAnd   = 4'd5,
    OpOr    = 4'd6,
    OpXor   = 4'd7,
    OpNot   = 4'd8,
    OpShftl = 4'd9,
    OpShftr = 4'd10,
    OpRotl  = 4'd11,
    OpRotr  = 4'd12,
    OpSwap  = 4'd13,
    OpCmp   = 4'd14,
    OpPass  = 4'd15
  } alu_op_e;

  typedef logic [1:0] exec_state_e;

  localparam exec_state_e StIdle  = 2'd0;
  localparam exec_state_e StExec  = 2'd1;
  localparam exec_state_e StShift = 2'd2;
  localparam exec_state_e StResp  = 2'd3;

endpackage

// File: rtl/alu_exec_unit_core.sv
// Combinational opcode decode and compute for the single-cycle ALU operations.
module alu_core
  import alu_pkg::*;
(
  input  alu_op_e        op_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic           carry_i,
  output logic [W-1:0]   result_o,
  output logic [W-1:0]   result_b_o,
  output logic           carry_o,
  output logic           carry_we_o
);

  logic [W:0] sum;

  always_comb begin
    result_o   = '0;
    result_b_o = '0;
    carry_o    = 1'b0;
    carry_we_o = 1'b0;
    sum        = '0;
    unique case (op_i)
      OpAdd: begin
        sum        = {1'b0, a_i} + {1'b0, b_i};
        result_o   = sum[W-1:0];
        carry_o    = sum[W];
        carry_we_o = 1'b1;
      end
      OpAddc: begin
        sum        = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, carry_i};
        result_o   = sum[W-1:0];
        carry_o    = sum[W];
        carry_we_o = 1'b1;
      end
      OpSub: begin
        result_o   = a_i - b_i;
        carry_o    = (a_i < b_i);
        carry_we_o = 1'b1;
      end
      OpInc: begin
        sum        = {1'b0, a_i} + (W+1)'(1);
        result_o   = sum[W-1:0];
        carry_o    = sum[W];
        carry_we_o = 1'b1;
      end
      OpDec: begin
        result_o   = a_i - W'(1);
        carry_o    = (a_i == '0);
        carry_we_o = 1'b1;
      end
      OpAnd:  result_o = a_i & b_i;
      OpOr:   result_o = a_i | b_i;
      OpXor:  result_o = a_i ^ b_i;
      OpNot:  result_o = ~a_i;
      // Only zero-count shifts reach the core; non-zero counts run serially in the wrapper.
      OpShftl, OpShftr: result_o = a_i;
      OpRotl: result_o = {a_i[W-2:0], a_i[W-1]};
      OpRotr: result_o = {a_i[0], a_i[W-1:1]};
      OpSwap: begin
        result_o   = b_i;
        result_b_o = a_i;
      end
      OpCmp:  result_o = a_i;
      OpPass: result_o = a_i;
      default: result_o = a_i;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Request/response execution wrapper: FSM, operand and serial-shift registers, flag registers.
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [OPW-1:0] req_op,
  input  logic [W-1:0]   req_a,
  input  logic [W-1:0]   req_b,
  input  logic [SHW-1:0] req_shamt,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_result,
  output logic [W-1:0]   rsp_result_b,
  output logic           rsp_zero,
  output logic           rsp_sign,
  output logic           rsp_carry
);

  exec_state_e    state_q, state_d;
  alu_op_e        op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sh_q, sh_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [W-1:0]   res_q, res_d;
  logic [W-1:0]   res_b_q, res_b_d;
  logic           zero_q, zero_d;
  logic           sign_q, sign_d;
  logic           carry_q, carry_d;

  logic [W-1:0]   core_result;
  logic [W-1:0]   core_result_b;
  logic           core_carry;
  logic           core_carry_we;
  logic [W-1:0]   sh_step;
  alu_op_e        req_op_e;
  logic           req_is_shift;

  alu_core u_core (
    .op_i       (op_q),
    .a_i        (a_q),
    .b_i        (b_q),
    .carry_i    (carry_q),
    .result_o   (core_result),
    .result_b_o (core_result_b),
    .carry_o    (core_carry),
    .carry_we_o (core_carry_we)
  );

  assign req_op_e     = alu_op_e'(req_op);
  assign req_is_shift = ((req_op_e == OpShftl) || (req_op_e == OpShftr)) && (req_shamt != '0);
  assign sh_step      = (op_q == OpShftl) ? {sh_q[W-2:0], 1'b0} : {1'b0, sh_q[W-1:1]};

  // Ready is masked by reset so nothing is advertised while the unit is held.
  assign req_ready    = rst_n && (state_q == StIdle);
  assign rsp_valid    = (state_q == StResp);
  assign rsp_result   = res_q;
  assign rsp_result_b = res_b_q;
  assign rsp_zero     = zero_q;
  assign rsp_sign     = sign_q;
  assign rsp_carry    = carry_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    res_b_d = res_b_q;
    zero_d  = zero_q;
    sign_d  = sign_q;
    carry_d = carry_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          op_d    = req_op_e;
          a_d     = req_a;
          b_d     = req_b;
          sh_d    = req_a;
          cnt_d   = req_shamt;
          state_d = req_is_shift ? StShift : StExec;
        end
      end
      StExec: begin
        res_d   = core_result;
        res_b_d = core_result_b;
        if (op_q == OpCmp) begin
          zero_d = (a_q == b_q);
          sign_d = (a_q < b_q);
        end else begin
          zero_d = (core_result == '0);
          sign_d = core_result[W-1];
        end
        if (core_carry_we) begin
          carry_d = core_carry;
        end
        state_d = StResp;
      end
      StShift: begin
        sh_d  = sh_step;
        cnt_d = cnt_q - SHW'(1);
        // The last shift position lands straight in the result registers.
        if (cnt_q == SHW'(1)) begin
          res_d   = sh_step;
          res_b_d = '0;
          zero_d  = (sh_step == '0);
          sign_d  = sh_step[W-1];
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= OpAdd;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      res_b_q <= '0;
      zero_q  <= 1'b0;
      sign_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      res_b_q <= res_b_d;
      zero_q  <= zero_d;
      sign_q  <= sign_d;
      carry_q <= carry_d;
    end
  end

endmodule
